// File: rtl/bsw_phase_gen.sv
// Phase sequencer for the bootstrapped sampling switch. Produces non-overlapping
// CK (track) / CKB (hold + bootstrap precharge) phases, enforces a minimum
// precharge time before each track phase, and hands the held sample to the SAR
// logic through a CONV_START / CONV_DONE handshake with timeout.
module bsw_phase_gen #(
  parameter int unsigned TRK_W   = 6,
  parameter int unsigned NOV_CYC = 1,
  parameter int unsigned MIN_PRE = 3,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             START,
  input  logic             CONT,
  input  logic [TRK_W-1:0] TRK_LEN,
  input  logic             CONV_DONE,
  output logic             CK,
  output logic             CKB,
  output logic             CONV_START,
  output logic             BUSY,
  output logic             TMO
);

  // One shared cycle counter serves dead-time, track length and conversion timeout.
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 2);
  localparam int unsigned NOV_W = $clog2(NOV_CYC + 2);
  localparam int unsigned CW_A  = (TRK_W > TMO_W) ? TRK_W : TMO_W;
  localparam int unsigned CNT_W = (CW_A > NOV_W) ? CW_A : NOV_W;
  localparam int unsigned PRE_W = $clog2(MIN_PRE + 2);

  localparam logic [CNT_W-1:0] NOV_LAST = CNT_W'(NOV_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_SAT  = PRE_W'(MIN_PRE);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StNov1  = 3'd1;
  localparam logic [2:0] StTrack = 3'd2;
  localparam logic [2:0] StNov2  = 3'd3;
  localparam logic [2:0] StConv  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [TRK_W-1:0] trk_len_q, trk_len_d;
  logic             start_pend_q, start_pend_d;
  logic             abort_q, abort_d;
  logic             timeout;
  logic             idle_exit;
  logic [CNT_W-1:0] trk_last;

  assign trk_last  = CNT_W'(trk_len_q) - CNT_W'(1);
  assign idle_exit = (state_q == StIdle) && EN && (start_pend_q || START || CONT) &&
                     (pre_cnt_q == PRE_SAT);

  // Next-state decode for the phase sequence.
  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    trk_len_d = trk_len_q;
    timeout   = 1'b0;
    case (state_q)
      StIdle: begin
        if (idle_exit) begin
          state_d   = StNov1;
          trk_len_d = (TRK_LEN == '0) ? TRK_W'(1) : TRK_LEN;
        end
      end
      StNov1: begin
        if (!EN) begin
          state_d = StNov2;
          abort_d = 1'b1;
        end else if (cnt_q == NOV_LAST) begin
          state_d = StTrack;
        end
      end
      StTrack: begin
        if (!EN) begin
          state_d = StNov2;
          abort_d = 1'b1;
        end else if (cnt_q == trk_last) begin
          state_d = StNov2;
        end
      end
      StNov2: begin
        if (cnt_q == NOV_LAST) begin
          state_d = abort_q ? StIdle : StConv;
          abort_d = 1'b0;
        end
      end
      StConv: begin
        // CONV_DONE has priority over an expiring timeout.
        if (CONV_DONE) begin
          state_d = StIdle;
        end else if (cnt_q == TMO_LAST) begin
          state_d = StIdle;
          timeout = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter, precharge tracking and request latch next-state.
  always_comb begin
    if (state_q == StIdle || state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // CKB is high in both IDLE and CONV, so conversion time counts as precharge.
    pre_cnt_d = pre_cnt_q;
    if (state_d == StConv && state_q != StConv) begin
      pre_cnt_d = '0;
    end else if ((state_q == StIdle || state_q == StConv) && pre_cnt_q != PRE_SAT) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end

    start_pend_d = start_pend_q;
    if (!EN || idle_exit) begin
      start_pend_d = 1'b0;
    end else if (START) begin
      start_pend_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pre_cnt_q    <= '0;
      trk_len_q    <= TRK_W'(1);
      start_pend_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      trk_len_q    <= trk_len_d;
      start_pend_q <= start_pend_d;
      abort_q      <= abort_d;
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      CK         <= 1'b0;
      CKB        <= 1'b1;
      CONV_START <= 1'b0;
      BUSY       <= 1'b0;
      TMO        <= 1'b0;
    end else begin
      CK         <= (state_d == StTrack);
      CKB        <= (state_d == StIdle) || (state_d == StConv);
      CONV_START <= (state_d == StConv) && (state_q != StConv);
      BUSY       <= (state_d != StIdle);
      TMO        <= timeout;
    end
  end

endmodule

// File: tb/tb_bsw_phase_gen.sv
// Scoreboard bench for bsw_phase_gen: stimulus pushes expected output events
// (with the cycle they must occur in) and a monitor pops and compares them.
module tb_bsw_phase_gen;

  localparam int unsigned TRK_W   = 6;
  localparam int unsigned NOV_CYC = 1;
  localparam int unsigned MIN_PRE = 3;
  localparam int unsigned TMO_CYC = 255;

  // Event kinds seen by the monitor, checked in this order within one cycle.
  localparam int EvCkRise   = 0;
  localparam int EvCkFall   = 1;
  localparam int EvConvSt   = 2;
  localparam int EvTmo      = 3;
  localparam int EvBusyFall = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic             CLK, RSTN, EN, START, CONT, CONV_DONE;
  logic [TRK_W-1:0] TRK_LEN;
  logic             CK, CKB, CONV_START, BUSY, TMO;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  logic mon_en = 1'b0;
  logic ck_prev, busy_prev;
  int  t;

  bsw_phase_gen #(
    .TRK_W  (TRK_W),
    .NOV_CYC(NOV_CYC),
    .MIN_PRE(MIN_PRE),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .EN        (EN),
    .START     (START),
    .CONT      (CONT),
    .TRK_LEN   (TRK_LEN),
    .CONV_DONE (CONV_DONE),
    .CK        (CK),
    .CKB       (CKB),
    .CONV_START(CONV_START),
    .BUSY      (BUSY),
    .TMO       (TMO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event_order: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: detects output events and checks the phase invariant every cycle.
  always @(negedge CLK) begin
    if (!mon_en) begin
      ck_prev   = CK;
      busy_prev = BUSY;
    end else begin
      chk("no_overlap", CK & CKB, 1'b0);
      if (CK && !ck_prev) see(EvCkRise);
      if (!CK && ck_prev) see(EvCkFall);
      if (CONV_START) see(EvConvSt);
      if (TMO) see(EvTmo);
      if (!BUSY && busy_prev) see(EvBusyFall);
      ck_prev   = CK;
      busy_prev = BUSY;
    end
  end

  initial begin
    RSTN = 1'b0; EN = 1'b0; START = 1'b0; CONT = 1'b0; CONV_DONE = 1'b0; TRK_LEN = 6'd4;
    tick(3);
    RSTN = 1'b1;

    // Asynchronous reset in the middle of a track phase.
    EN = 1'b1;
    tick(6);
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(2);
    chk("track_before_reset", CK, 1'b1);
    #3 RSTN = 1'b0;
    #1;
    chk("async_rst_ck", CK, 1'b0);
    chk("async_rst_ckb", CKB, 1'b1);
    chk("async_rst_busy", BUSY, 1'b0);
    tick(2);
    RSTN = 1'b1;
    mon_en = 1'b1;
    chk("rst_ck", CK, 1'b0);
    chk("rst_ckb", CKB, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_tmo", TMO, 1'b0);
    chk("rst_conv_start", CONV_START, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_no_ck", CK, 1'b0);
    end

    // Single sample, TRK_LEN=4.
    t = cyc;
    START = 1'b1;
    push(EvCkRise, t + 2); push(EvCkFall, t + 6); push(EvConvSt, t + 7);
    push(EvBusyFall, t + 11);
    tick(1);
    START = 1'b0;
    chk("nov1_ck", CK, 1'b0);
    chk("nov1_ckb", CKB, 1'b0);
    tick(5);
    chk("nov2_ck", CK, 1'b0);
    chk("nov2_ckb", CKB, 1'b0);
    tick(1);
    chk("conv_ckb", CKB, 1'b1);
    tick(3);
    CONV_DONE = 1'b1;
    tick(1);
    CONV_DONE = 1'b0;
    chk("single_busy_low", BUSY, 1'b0);

    // Timeout with CONV_DONE held low.
    tick(4);
    t = cyc;
    START = 1'b1;
    push(EvCkRise, t + 2); push(EvCkFall, t + 6); push(EvConvSt, t + 7);
    push(EvTmo, t + 7 + TMO_CYC); push(EvBusyFall, t + 7 + TMO_CYC);
    tick(1);
    START = 1'b0;
    tick(261);
    chk("tmo_pulse", TMO, 1'b1);
    chk("tmo_busy_low", BUSY, 1'b0);
    tick(1);
    chk("tmo_one_cycle", TMO, 1'b0);

    // CONV_DONE in the timeout cycle suppresses TMO.
    tick(4);
    t = cyc;
    START = 1'b1;
    push(EvCkRise, t + 2); push(EvCkFall, t + 6); push(EvConvSt, t + 7);
    push(EvBusyFall, t + 7 + TMO_CYC);
    tick(1);
    START = 1'b0;
    tick(260);
    CONV_DONE = 1'b1;
    tick(1);
    CONV_DONE = 1'b0;
    chk("tmo_suppressed", TMO, 1'b0);
    chk("suppress_busy_low", BUSY, 1'b0);

    // Continuous mode, TRK_LEN=0 (treated as 1), 7-cycle period.
    tick(4);
    t = cyc;
    TRK_LEN = 6'd0;
    CONT = 1'b1;
    for (int k = 0; k < 143; k++) begin
      push(EvCkRise, t + 2 + 7 * k); push(EvCkFall, t + 3 + 7 * k);
      push(EvConvSt, t + 4 + 7 * k); push(EvBusyFall, t + 6 + 7 * k);
    end
    tick(5);
    for (int k = 0; k < 143; k++) begin
      CONV_DONE = 1'b1;
      if (k == 142) CONT = 1'b0;
      tick(1);
      CONV_DONE = 1'b0;
      if (k != 142) tick(6);
    end
    chk("cont_end_busy_low", BUSY, 1'b0);
    tick(10);

    // Abort: EN dropped on the second track cycle, with a pending START.
    TRK_LEN = 6'd4;
    tick(4);
    t = cyc;
    START = 1'b1;
    push(EvCkRise, t + 2); push(EvCkFall, t + 4); push(EvBusyFall, t + 5);
    tick(1);
    START = 1'b0;
    tick(1);
    START = 1'b1;
    tick(1);
    START = 1'b0;
    EN = 1'b0;
    tick(1);
    chk("abort_ck_low", CK, 1'b0);
    chk("abort_ckb_low", CKB, 1'b0);
    tick(1);
    chk("abort_idle_busy", BUSY, 1'b0);
    chk("abort_idle_ckb", CKB, 1'b1);
    CONV_DONE = 1'b1;
    tick(1);
    CONV_DONE = 1'b0;
    EN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("abort_no_restart", BUSY, 1'b0);
    end

    // Pending request: two STARTs during CONV give exactly one extra sample.
    t = cyc;
    START = 1'b1;
    push(EvCkRise, t + 2); push(EvCkFall, t + 6); push(EvConvSt, t + 7);
    push(EvBusyFall, t + 12);
    push(EvCkRise, t + 14); push(EvCkFall, t + 23); push(EvConvSt, t + 24);
    push(EvBusyFall, t + 26);
    tick(1);
    START = 1'b0;
    tick(2);
    TRK_LEN = 6'd9;
    tick(5);
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(1);
    START = 1'b1;
    tick(1);
    START = 1'b0;
    CONV_DONE = 1'b1;
    tick(1);
    CONV_DONE = 1'b0;
    chk("pend_gap_busy_low", BUSY, 1'b0);
    tick(12);
    chk("pend_conv_start", CONV_START, 1'b1);
    tick(1);
    CONV_DONE = 1'b1;
    tick(1);
    CONV_DONE = 1'b0;
    chk("pend_done_busy_low", BUSY, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("pend_no_third", BUSY, 1'b0);
    end

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d events outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
